// File: rtl/l1_trigger_decision.sv
// ---------------------------------------------------------------------------
// l1_trigger_decision
//
// Accumulates the signed hidden-neuron outputs of one event into a saturating
// score. When the last beat arrives it compares the score against a signed
// threshold and issues an accept decision one cycle later. After each accept,
// further accepts are blocked for DEADTIME cycles. Above-threshold events that
// arrive during that window are counted as vetoes.
//
// Parameters
//   ACC_W     width of the signed score accumulator (must be >= 16)
//   DEADTIME  accept-suppression length in cycles; 0 disables it
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous active-high reset
//   in_valid      in_data / in_last valid this cycle (no backpressure)
//   in_data       signed 16-bit beat value
//   in_last       final beat of the event (qualified by in_valid)
//   threshold     signed 16-bit accept threshold
//   out_valid     one-cycle pulse: a decision is presented
//   trig_accept   one-cycle pulse with out_valid: the event was accepted
//   trig_score    signed final score, held until the next decision
//   dead_active   deadtime counter is nonzero
//   accept_count  saturating count of accepted events
//   veto_count    saturating count of above-threshold events blocked by deadtime
// ---------------------------------------------------------------------------
module l1_trigger_decision #(
  parameter int ACC_W    = 20,
  parameter int DEADTIME = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             in_last,
  input  logic [15:0]      threshold,
  output logic             out_valid,
  output logic             trig_accept,
  output logic [ACC_W-1:0] trig_score,
  output logic             dead_active,
  output logic [15:0]      accept_count,
  output logic [15:0]      veto_count
);

  localparam int DW = (DEADTIME < 1) ? 1 : $clog2(DEADTIME + 1);
  localparam logic [DW-1:0] DEAD_LOAD = DW'(DEADTIME);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [DW-1:0]           dead_reg, dead_next;
  logic                    out_valid_reg, trig_accept_reg;
  logic signed [ACC_W-1:0] trig_score_reg;
  logic [15:0]             accept_count_reg, veto_count_reg;

  logic signed [ACC_W-1:0] data_ext, thr_ext, acc_base, sum_sat;
  logic signed [ACC_W:0]   sum_wide;
  logic                    dec_valid, candidate, accept_fire, veto_fire;

  assign data_ext = ACC_W'(signed'(in_data));
  assign thr_ext  = ACC_W'(signed'(threshold));

  // A fresh event starts from zero, so the first beat and a single-beat
  // event share the same adder path as the continuing case.
  assign acc_base = (state_reg == ACCUM) ? acc_reg : '0;

  // One extra bit catches overflow: the top two bits disagree only when
  // the true sum left the ACC_W range, and the top bit gives the direction.
  assign sum_wide = {acc_base[ACC_W-1], acc_base} + {data_ext[ACC_W-1], data_ext};
  always_comb begin
    sum_sat = sum_wide[ACC_W-1:0];
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
      sum_sat = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    end
  end

  assign candidate = (sum_sat >= thr_ext);

  // Next-state / datapath logic
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    dec_valid  = 1'b0;
    if (in_valid) begin
      if (in_last) begin
        acc_next   = '0;
        state_next = IDLE;
        dec_valid  = 1'b1;
      end else begin
        acc_next   = sum_sat;
        state_next = ACCUM;
      end
    end
  end

  // The deadtime value seen here is the one before this edge, so an event
  // closing on the cycle right after an accept is still blocked.
  assign accept_fire = dec_valid && candidate && (dead_reg == '0);
  assign veto_fire   = dec_valid && candidate && (dead_reg != '0);

  always_comb begin
    dead_next = dead_reg;
    if (accept_fire) begin
      dead_next = DEAD_LOAD;
    end else if (dead_reg != '0) begin
      dead_next = dead_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      acc_reg          <= '0;
      dead_reg         <= '0;
      out_valid_reg    <= 1'b0;
      trig_accept_reg  <= 1'b0;
      trig_score_reg   <= '0;
      accept_count_reg <= '0;
      veto_count_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      acc_reg         <= acc_next;
      dead_reg        <= dead_next;
      out_valid_reg   <= dec_valid;
      trig_accept_reg <= accept_fire;
      if (dec_valid) begin
        trig_score_reg <= sum_sat;
      end
      if (accept_fire && (accept_count_reg != 16'hFFFF)) begin
        accept_count_reg <= accept_count_reg + 16'd1;
      end
      if (veto_fire && (veto_count_reg != 16'hFFFF)) begin
        veto_count_reg <= veto_count_reg + 16'd1;
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign trig_accept  = trig_accept_reg;
  assign trig_score   = trig_score_reg;
  assign dead_active  = (dead_reg != '0);
  assign accept_count = accept_count_reg;
  assign veto_count   = veto_count_reg;

endmodule

// File: tb/tb_l1_trigger_decision.sv
// ---------------------------------------------------------------------------
// tb_l1_trigger_decision
//
// Directed scenarios followed by randomized traffic, all checked every cycle
// against a timestamp-based reference model of the trigger decision.
// ---------------------------------------------------------------------------
module tb_l1_trigger_decision;

  localparam int ACC_W    = 20;
  localparam int DEADTIME = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic [15:0]      threshold = '0;
  logic             out_valid, trig_accept, dead_active;
  logic [ACC_W-1:0] trig_score;
  logic [15:0]      accept_count, veto_count;

  l1_trigger_decision #(.ACC_W(ACC_W), .DEADTIME(DEADTIME)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .threshold(threshold), .out_valid(out_valid),
    .trig_accept(trig_accept), .trig_score(trig_score),
    .dead_active(dead_active), .accept_count(accept_count),
    .veto_count(veto_count)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the running sum is a plain integer clamped to the
  // ACC_W range, and deadtime is tracked as the edge number of the last
  // accept rather than as a down-counter.
  longint cyc = 0;
  longint m_sum = 0;
  bit     m_open = 0;
  longint m_last_acc = -(64'sd1 <<< 30);
  bit     exp_ov = 0, exp_ta = 0, exp_dead = 0;
  longint exp_score = 0;
  int     exp_acc_cnt = 0, exp_veto_cnt = 0;

  function automatic longint clamp(input longint x);
    longint hi, lo;
    hi = (64'sd1 <<< (ACC_W - 1)) - 1;
    lo = -(64'sd1 <<< (ACC_W - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  task automatic model_reset();
    m_sum = 0; m_open = 0; m_last_acc = -(64'sd1 <<< 30);
    exp_ov = 0; exp_ta = 0; exp_dead = 0; exp_score = 0;
    exp_acc_cnt = 0; exp_veto_cnt = 0;
  endtask

  task automatic model_edge(input logic v, input logic [15:0] d, input logic l);
    longint s;
    exp_ov = 0;
    exp_ta = 0;
    if (v) begin
      s = clamp((m_open ? m_sum : 0) + longint'($signed(d)));
      if (l) begin
        exp_ov = 1;
        exp_score = s;
        if (s >= longint'($signed(threshold))) begin
          if (cyc - m_last_acc > DEADTIME) begin
            exp_ta = 1;
            m_last_acc = cyc;
            if (exp_acc_cnt < 65535) exp_acc_cnt++;
          end else if (exp_veto_cnt < 65535) begin
            exp_veto_cnt++;
          end
        end
        m_sum = 0;
        m_open = 0;
      end else begin
        m_sum = s;
        m_open = 1;
      end
    end
    exp_dead = (cyc - m_last_acc) < DEADTIME;
  endtask

  task automatic check_outputs();
    logic [ACC_W-1:0] sc;
    sc = exp_score[ACC_W-1:0];
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("trig_accept", 32'(trig_accept), 32'(exp_ta));
    check("trig_score", 32'(trig_score), 32'(sc));
    check("dead_active", 32'(dead_active), 32'(exp_dead));
    check("accept_count", 32'(accept_count), 32'(exp_acc_cnt));
    check("veto_count", 32'(veto_count), 32'(exp_veto_cnt));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 time unit after the edge that consumed them.
  task automatic step(input logic v, input logic [15:0] d, input logic l);
    in_valid = v; in_data = d; in_last = l;
    @(posedge clk);
    cyc++;
    model_edge(v, d, l);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
  endtask

  // Reset is raised between edges so its asynchronous effect is visible
  // before any clock edge; it is held across one edge, then released.
  task automatic do_reset();
    in_valid = 0; in_last = 0;
    rst = 1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    cyc++;
    #1;
    check_outputs();
    rst = 0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Accepted three-beat event, then the deadtime window
    threshold = 16'd100;
    step(1, 16'd30, 0); step(1, 16'd40, 0); step(1, 16'd50, 1);
    check("r33_score", 32'(trig_score), 32'd120);
    check("r33_accept", 32'(trig_accept), 32'd1);
    idle(6);

    // Just below threshold
    step(1, 16'd30, 0); step(1, 16'd40, 0); step(1, 16'd29, 1);
    check("r34_score", 32'(trig_score), 32'd99);
    check("r34_accept", 32'(trig_accept), 32'd0);
    idle(6);

    // Second above-threshold event inside the deadtime window is vetoed
    step(1, 16'd200, 1); idle(1); step(1, 16'd200, 1);
    check("r35_accept", 32'(trig_accept), 32'd0);
    check("r35_accept_count", 32'(accept_count), 32'd2);
    check("r35_veto_count", 32'(veto_count), 32'd1);
    idle(6);

    // Positive saturation
    for (int i = 0; i < 19; i++) step(1, 16'h7FFF, 0);
    step(1, 16'h7FFF, 1);
    check("r36_sat_pos", 32'(trig_score), 32'h7FFFF);
    idle(6);

    // Negative saturation
    for (int i = 0; i < 19; i++) step(1, 16'h8000, 0);
    step(1, 16'h8000, 1);
    check("sat_neg", 32'(trig_score), 32'h80000);
    idle(2);

    // Reset mid-event discards the partial sum
    step(1, 16'd5, 0); step(1, 16'd6, 0);
    do_reset();
    step(1, 16'd10, 1);
    check("r37_score", 32'(trig_score), 32'd10);
    idle(2);

    // Reset in the cycle the decision would be presented
    step(1, 16'd200, 1);
    do_reset();
    check("r32_no_valid", 32'(out_valid), 32'd0);
    idle(2);

    // Gap inside an event
    threshold = 16'd120;
    step(1, 16'd60, 0); idle(5); step(1, 16'd60, 1);
    check("r38_score", 32'(trig_score), 32'd120);
    check("r38_accept", 32'(trig_accept), 32'd1);
    idle(6);

    // Back-to-back single-beat events
    threshold = 16'hFF00;
    step(1, 16'd1, 1);
    step(1, 16'd2, 1);
    check("b2b_valid", 32'(out_valid), 32'd1);
    check("b2b_score", 32'(trig_score), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic v, l;
      logic [15:0] d;
      int sel;
      if (n % 700 == 699) do_reset();
      if ($urandom_range(0, 19) == 0)
        threshold = 16'($signed($urandom_range(0, 600)) - 200);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      d = 16'h7FFF;
      else if (sel == 1) d = 16'h8000;
      else               d = 16'($signed($urandom_range(0, 600)) - 300);
      step(v, d, l);
    end

    in_valid = 0; in_last = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/l1_trigger_decision.md
L1_TRIGGER_DECISION -- requirements
Module: l1_trigger_decision

Interface
REQ-001 Parameter ACC_W, default 20: width of the signed event-score accumulator.
REQ-002 Parameter DEADTIME, default 4: cycles of accept suppression after each accept; 0 disables deadtime.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  in_data/in_last valid this cycle; no backpressure.
REQ-006 in_data  input  16  signed hidden-neuron output (ReLU y) for the current event.
REQ-007 in_last  input  1  qualifies the final beat of an event; ignored when in_valid=0.
REQ-008 threshold  input  16  signed accept threshold, sign-extended to ACC_W for compare.
REQ-009 out_valid  output  1  one-cycle pulse: decision for one event is presented.
REQ-010 trig_accept  output  1  one-cycle pulse, only with out_valid: event accepted.
REQ-011 trig_score  output  ACC_W  signed final event score; held until the next out_valid.
REQ-012 dead_active  output  1  high while the deadtime counter is nonzero.
REQ-013 accept_count  output  16  events accepted since reset, saturating.
REQ-014 veto_count  output  16  events above threshold but suppressed by deadtime, saturating.

Function
REQ-015 States: IDLE (no event open), ACCUM (at least one beat of the current event received).
REQ-016 IDLE, in_valid=1, in_last=0: acc <= sext(in_data); go to ACCUM.
REQ-017 ACCUM, in_valid=1, in_last=0: acc <= sat(acc + sext(in_data)); stay in ACCUM.
REQ-018 Any state, in_valid=1, in_last=1: score = sat(acc_or_0 + sext(in_data)), where acc_or_0 is 0 in IDLE; trig_score <= score; acc <= 0; go to IDLE; out_valid=1 on the next cycle.
REQ-019 A single-beat event (in_last=1 in IDLE) is legal; score = in_data.
REQ-020 in_valid=0: acc and state hold; gaps inside an event are legal.
REQ-021 sat() clamps the signed ACC_W result to [-(2^(ACC_W-1)), 2^(ACC_W-1)-1]; no wrap-around.
REQ-022 Decision latency: exactly 1 cycle from the in_last beat edge to out_valid/trig_accept high.
REQ-023 Decision: candidate = (score >= sext(threshold)), signed compare.
REQ-024 candidate and dead counter = 0: trig_accept=1; accept_count++; dead counter <= DEADTIME.
REQ-025 candidate and dead counter != 0: trig_accept=0; veto_count++; dead counter is not reloaded.
REQ-026 Not candidate: trig_accept=0; no counter changes.
REQ-027 Dead counter decrements by 1 each cycle while nonzero, including the load cycle's successor; dead_active = (counter != 0).
REQ-028 Back-to-back events (in_last on consecutive cycles) each produce their own out_valid on consecutive cycles.
REQ-029 accept_count and veto_count stop at 16'hFFFF.

Reset
REQ-030 rst=1 immediately forces: state IDLE, acc 0, dead counter 0, out_valid 0, trig_accept 0, trig_score 0, dead_active 0, accept_count 0, veto_count 0.
REQ-031 Reset mid-event discards the partial sum; the next beat after reset release starts a new event.
REQ-032 Reset asserted in the cycle a decision would be presented suppresses that out_valid and any count update.

Verification
REQ-033 threshold=100, beats 30,40,50 (last): out_valid and trig_accept pulse 1 cycle after the last beat, trig_score=120, accept_count=1, dead_active=1 for 4 cycles.
REQ-034 threshold=100, beats 30,40,29 (last): out_valid=1, trig_accept=0, trig_score=99, counters unchanged.
REQ-035 DEADTIME=4, two single-beat events of 200 two cycles apart, threshold=100: first accepted, second vetoed; accept_count=1, veto_count=1.
REQ-036 ACC_W=20, 20 beats of 32767: trig_score saturates at 524287, not wrapped.
REQ-037 rst pulsed after 2 of 3 beats: no out_valid; subsequent event 10 (last) gives trig_score=10.
REQ-038 Gap of 5 idle cycles between beats 60 and 60 (last), threshold=120: trig_accept=1, trig_score=120.
